plot_sink: RTL
==============

Name: plot_sink

Overview:
- Receiving end of the pixel-plot interface driven by the drawing engines (circle, reuleaux, fill).
- Accepts one plot per cycle, clips off-screen coordinates, and stores 3-bit colour into a 160x120 framebuffer.
- Provides a hardware clear and a registered readback port, used by the scan-out logic and by testbenches to check drawn shapes.

Parameters:
- SCR_W, 160, screen width in pixels
- SCR_H, 120, screen height in pixels
- CNT_W, 16, width of the plot and reject counters

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, reset is synchronous and active-high
- vga_x  in  8  plot x coordinate
- vga_y  in  7  plot y coordinate
- vga_colour  in  3  plot colour
- vga_plot  in  1  plot strobe; one pixel per cycle while high
- clr_start  in  1  level request to clear the whole framebuffer
- clr_colour  in  3  fill colour for clear, sampled on the IDLE->CLEAR cycle
- clr_done  out  1  high in DONE state
- busy  out  1  high in CLEAR state
- rd_req  in  1  readback request
- rd_x  in  8  readback x
- rd_y  in  7  readback y
- rd_valid  out  1  readback data valid
- rd_colour  out  3  readback colour
- plot_cnt  out  CNT_W  accepted plots, saturating
- rej_cnt  out  CNT_W  clipped or dropped plots, saturating

Behaviour:
- Reset, when rst is high at a clk edge:
  - state=IDLE, busy=0, clr_done=0, rd_valid=0, rd_colour=0, plot_cnt=0, rej_cnt=0.
  - Framebuffer contents are not reset.
- Address = y*SCR_W + x, 15 bits. Implement as (y<<7)+(y<<5)+x, no multiplier. Pixel (159,119) maps to 19199.
- Plot path, state IDLE or DONE, vga_plot=1:
  - If x<SCR_W and y<SCR_H: write colour at the next edge; plot_cnt+1.
  - Otherwise: no write; rej_cnt+1.
  - Coordinates x>=160 or y>=120, including values wrapped by engine underflow such as 255, are rejected.
- State machine:
  - IDLE: clr_start=1 -> CLEAR. Latch clr_colour and set clear pointer cx=0, cy=0.
  - CLEAR: each cycle write the latched colour at (cx,cy), advancing x first then y. After writing (159,119) -> DONE, so CLEAR lasts exactly 19200 cycles. busy=1.
  - DONE: clr_done=1. clr_start=0 -> IDLE. Plots are accepted in DONE.
  - clr_start dropping mid-CLEAR does not abort the clear; the sequence completes, then DONE goes to IDLE on the next cycle.
  - Plots arriving during CLEAR are not written and increment rej_cnt.
- Write-port priority: CLEAR write over plot. Only one write per cycle.
- Readback:
  - rd_req=1 at edge N -> rd_valid=1 and rd_colour valid at edge N+1, so latency is 1 and the port is fully pipelined.
  - Out-of-range rd_x/rd_y returns rd_colour=0 with rd_valid=1.
  - Readback is independent of state and is allowed during CLEAR.
- Same-cycle read and write to the same address: read returns the old data (read-before-write).
- Counters saturate at all-ones and do not wrap.
- Reset mid-CLEAR: returns to IDLE on that edge. Partially cleared memory is left as is.

Decomposition:
- Package plot_pkg holds:
  - SCR_W/SCR_H defaults
  - the state enum typedef (IDLE, CLEAR, DONE)
  - the pixel struct typedef {x[7:0], y[6:0], colour[2:0]}
  - the address-width constant (15)
- Sub-module fb_ram: simple dual-port RAM, 19200x3, one write port and one registered read port, read-before-write. Inferable as block RAM.

Test Plan:
- Reset, then plot (10,20) colour 5, then rd_req at (10,20) -> rd_valid one cycle after the request, rd_colour=5, plot_cnt=1, rej_cnt=0.
- Plot (160,0), (0,120), (255,127) -> no memory change (readback at (0,0) still the prior value), rej_cnt=3, plot_cnt unchanged.
- Assert clr_start with clr_colour=3 -> busy high for exactly 19200 cycles, then clr_done=1. Readback at (0,0), (159,119) and (80,60) returns 3. Deassert clr_start -> clr_done=0 the next cycle.
- Plot (5,5) colour 7 on every cycle of a clear -> rej_cnt increments by 19200 and (5,5) reads as the clear colour afterwards.
- Write (1,1) colour 2, then in one cycle plot (1,1) colour 6 with rd_req (1,1) -> returns 2. A read on the next cycle returns 6.
- Drive rst high 100 cycles into a clear -> state IDLE, busy=0, counters 0. A new clear then completes normally in 19200 cycles.

Source files
------------

// File: rtl/plot_pkg.sv
// Shared types and constants for the pixel-plot sink and its framebuffer.
package plot_pkg;

  localparam int unsigned SCR_W_DEF = 160;
  localparam int unsigned SCR_H_DEF = 120;
  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned ADDR_W    = 15;
  localparam int unsigned X_W       = 8;
  localparam int unsigned Y_W       = 7;
  localparam int unsigned COL_W     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [COL_W-1:0] colour;
  } pixel_t;

  // Linear pixel address y*160 + x built from shifts (160 = 128 + 32).
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [X_W-1:0] x,
                                                 input logic [Y_W-1:0] y);
    return ADDR_W'({y, 7'd0}) + ADDR_W'({y, 5'd0}) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/plot_sink_fb_ram.sv
// Simple dual-port framebuffer: one write port, one registered read-before-write port.
module fb_ram #(
  parameter int unsigned DEPTH = 19200,
  parameter int unsigned AW    = 15,
  parameter int unsigned DW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic          rd_ok,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_data_q;

  // Write port; memory contents are never reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; returns old data on a same-address write, zero when off-screen.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (re) begin
      rd_data_q <= rd_ok ? mem[raddr] : '0;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/plot_sink.sv
// Pixel-plot receiver: clips plots, runs hardware clear, and serves readback.
module plot_sink
  import plot_pkg::*;
#(
  parameter int unsigned SCR_W = SCR_W_DEF,
  parameter int unsigned SCR_H = SCR_H_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       vga_x,
  input  logic [6:0]       vga_y,
  input  logic [2:0]       vga_colour,
  input  logic             vga_plot,
  input  logic             clr_start,
  input  logic [2:0]       clr_colour,
  output logic             clr_done,
  output logic             busy,
  input  logic             rd_req,
  input  logic [7:0]       rd_x,
  input  logic [6:0]       rd_y,
  output logic             rd_valid,
  output logic [2:0]       rd_colour,
  output logic [CNT_W-1:0] plot_cnt,
  output logic [CNT_W-1:0] rej_cnt
);

  localparam logic [X_W-1:0] X_LIM  = X_W'(SCR_W);
  localparam logic [Y_W-1:0] Y_LIM  = Y_W'(SCR_H);
  localparam logic [X_W-1:0] X_LAST = X_W'(SCR_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCR_H - 1);

  state_e           state_q, state_d;
  logic [X_W-1:0]   cx_q, cx_d;
  logic [Y_W-1:0]   cy_q, cy_d;
  logic [COL_W-1:0] clr_col_q, clr_col_d;
  logic [CNT_W-1:0] plot_cnt_q, plot_cnt_d;
  logic [CNT_W-1:0] rej_cnt_q, rej_cnt_d;
  logic             busy_q, busy_d;
  logic             clr_done_q, clr_done_d;
  logic             rd_valid_q, rd_valid_d;

  pixel_t           plot_px;
  logic             plot_ok;
  logic             rd_ok;
  logic             we;
  logic [ADDR_W-1:0] waddr;
  logic [COL_W-1:0] wdata;

  assign plot_px = '{x: vga_x, y: vga_y, colour: vga_colour};
  assign plot_ok = (plot_px.x < X_LIM) && (plot_px.y < Y_LIM);
  assign rd_ok   = (rd_x < X_LIM) && (rd_y < Y_LIM);

  // State register, clear pointer, counters and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cx_q       <= '0;
      cy_q       <= '0;
      clr_col_q  <= '0;
      plot_cnt_q <= '0;
      rej_cnt_q  <= '0;
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      clr_col_q  <= clr_col_d;
      plot_cnt_q <= plot_cnt_d;
      rej_cnt_q  <= rej_cnt_d;
      busy_q     <= busy_d;
      clr_done_q <= clr_done_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Next-state, single write-port arbitration (clear wins) and counter updates.
  always_comb begin
    state_d    = state_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    clr_col_d  = clr_col_q;
    plot_cnt_d = plot_cnt_q;
    rej_cnt_d  = rej_cnt_q;
    we         = 1'b0;
    waddr      = pix_addr(plot_px.x, plot_px.y);
    wdata      = plot_px.colour;

    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d   = CLEAR;
          clr_col_d = clr_colour;
          cx_d      = '0;
          cy_d      = '0;
        end
      end
      CLEAR: begin
        we    = 1'b1;
        waddr = pix_addr(cx_q, cy_q);
        wdata = clr_col_q;
        if (cx_q == X_LAST) begin
          cx_d = '0;
          if (cy_q == Y_LAST) begin
            state_d = DONE;
          end else begin
            cy_d = cy_q + Y_W'(1);
          end
        end else begin
          cx_d = cx_q + X_W'(1);
        end
      end
      DONE: begin
        if (!clr_start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (vga_plot) begin
      if ((state_q != CLEAR) && plot_ok) begin
        we = 1'b1;
        if (!(&plot_cnt_q)) plot_cnt_d = plot_cnt_q + CNT_W'(1);
      end else begin
        if (!(&rej_cnt_q)) rej_cnt_d = rej_cnt_q + CNT_W'(1);
      end
    end

    busy_d     = (state_d == CLEAR);
    clr_done_d = (state_d == DONE);
    rd_valid_d = rd_req;
  end

  fb_ram #(
    .DEPTH (SCR_W * SCR_H),
    .AW    (ADDR_W),
    .DW    (COL_W)
  ) u_fb_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .re      (rd_req),
    .rd_ok   (rd_ok),
    .raddr   (pix_addr(rd_x, rd_y)),
    .rd_data (rd_colour)
  );

  assign busy     = busy_q;
  assign clr_done = clr_done_q;
  assign rd_valid = rd_valid_q;
  assign plot_cnt = plot_cnt_q;
  assign rej_cnt  = rej_cnt_q;

endmodule
